can_stuff: RTL
==============

Name: can_stuff

Overview:
- Transmit-side CAN bit stuffer, the TX counterpart of the unstuffing receiver.
- Takes the unstuffed frame bit stream from the frame serializer, one bit per baud tick, over a ready/valid handshake.
- Drives the CAN TX line. After CONSEC identical consecutive bits it inserts one complementary stuff bit, stalling the source for that bit time.
- Sits between the frame serializer and the transceiver pin.

Parameters:
- CONSEC, 5, run length of identical bits that triggers one stuff bit (legal range 2..15).
- CNT_W, 4, width of the run counter; must satisfy 2^CNT_W > CONSEC.

Ports:
- clkin  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- bit_tick  in  1  one-clkin-cycle strobe marking each CAN bit boundary.
- en  in  1  1 = stuffing active (SOF through CRC); 0 = pass-through (CRC delimiter, ACK, EOF, idle).
- din_valid  in  1  source has a bit on din.
- din  in  1  unstuffed bit (0 = dominant).
- din_ready  out  1  combinational; din consumed this cycle.
- txout  out  1  registered TX line.
- stuffing  out  1  registered; high for the bit time in which txout carries a stuff bit.
- err  out  1  sticky underrun flag.

Behaviour:
- Reset: txout=1 (recessive), stuffing=0, err=0, run count=0, last bit=1, state=IDLE. Async assert; deassert takes effect on the next posedge.
- Everything except din_ready updates only on cycles with bit_tick=1. Between ticks all registers hold.
- din_ready = bit_tick && state!=STUFF && din_valid. It is never high outside a tick. A transfer occurs when din_valid && din_ready.
- Latency: a bit consumed at tick N appears on txout from the clkin cycle after tick N and holds until the cycle after tick N+1.

States:
- IDLE (en=0):
  - At a tick with din_valid: txout<=din, count<=0, last<=din.
  - At a tick with no din_valid: txout<=1, no error.
  - Go to DATA when en=1 at a tick.
- DATA (en=1):
  - At a tick with din_valid: txout<=din, last<=din.
  - count<=(din==last && count!=0) ? count+1 : 1.
  - If the new count==CONSEC, go to STUFF.
  - At a tick with din_valid=0 (underrun): txout<=1, err<=1, count<=0. Stay in DATA.
- STUFF:
  - At a tick: txout<=!last, last<=!last, count<=1, stuffing<=1, din_ready=0, go to DATA.
  - The stuff bit starts a new run. Example: 00000 1 1111 gives a second stuff bit after the 4th data 1.
- stuffing clears at the next tick that is not a stuff tick.

en transitions:
- en falling while in DATA: honoured at the next tick. If the last data bit completed a run, the pending stuff bit is still emitted (CRC-final stuff bit). Return to IDLE after it.
- en falling while in STUFF: the stuff bit is emitted first, then IDLE.

Other rules:
- Count saturates at CONSEC and never wraps.
- bit_tick while rstn=0: ignored.
- err clears only on reset.

Optional Feature:
- Macro: CAN_STUFF_BITMON_EN.
- When defined:
  - Adds input rxin (1 bit, resynchronised bus readback) and output bit_err (sticky).
  - At each bit_tick, if txout drove dominant (0) and rxin reads recessive (1), bit_err<=1. Recessive-read-dominant is arbitration loss and is not flagged.
  - bit_err clears on reset.
- When undefined: no rxin or bit_err ports; behaviour otherwise identical.

Decomposition:
- Shared package can_pkg:
  - CAN_DOMINANT=1'b0 and CAN_RECESSIVE=1'b1.
  - CAN_CONSEC_DEFAULT=5.
  - Enum can_stuff_state_t {IDLE, DATA, STUFF}. The unstuffer and frame serializer reuse these.
- One natural sub-module: can_run_counter (inputs bit, tick, clear; outputs count and run_hit).
  - Shared with the receive-side unstuffer for equivalent run detection.

Test Plan:
- en=1, feed 0,0,0,0,0,1 with din_valid=1 on every tick → txout sequence 0,0,0,0,0,1(stuff),1. stuffing high only on the 6th bit time. din_ready low on the 6th tick.
- en=1, feed 0×5 then 1×4 then 0 → txout 0,0,0,0,0,1s,1,1,1,1,0s,0. The stuff bit counts toward the following run.
- en=1, feed alternating 1,0 for 20 bits → no stuff bits, stuffing always 0, txout equals din delayed one tick.
- en=1, feed 1×5 with en dropped on the tick after the 5th bit → stuff bit 0 still emitted, then IDLE. Later runs of 1×8 with en=0 pass unstuffed.
- en=1, din_valid=0 on one tick mid-frame → txout=1, err=1 and stays set. Asserting rstn=0 mid-STUFF → txout=1, stuffing=0, err=0 immediately.
- With CAN_STUFF_BITMON_EN: drive txout 0 while forcing rxin=1 → bit_err=1. Drive txout 1 with rxin=0 → bit_err stays 0.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: bus levels, default stuff run length and the stuffer state type.
// Reused by the stuffer, the unstuffer and the frame serializer.
package can_pkg;

    localparam logic CAN_DOMINANT       = 1'b0;
    localparam logic CAN_RECESSIVE      = 1'b1;
    localparam int   CAN_CONSEC_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } can_stuff_state_t;

endpackage

// File: rtl/can_run_counter.sv
// Run-length tracker for identical consecutive CAN bits, shared by the TX stuffer and RX unstuffer.
// run_hit reports that advancing with bit_in would complete a run of CONSEC bits.
module can_run_counter
    import can_pkg::*;
#(
    parameter int CONSEC = CAN_CONSEC_DEFAULT,
    parameter int CNT_W  = 4
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             tick,
    input  logic             clear,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count,
    output logic             last_bit,
    output logic             run_hit
);

    localparam logic [CNT_W-1:0] CONSEC_C = CNT_W'(CONSEC);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d, adv_count;
    logic             last_q, last_d;

    // A zero count means no run is open, so the next bit always starts a fresh run of one.
    assign adv_count = (bit_in == last_q && count_q != '0)
                     ? ((count_q >= CONSEC_C) ? CONSEC_C : count_q + ONE_C)
                     : ONE_C;
    assign run_hit   = (adv_count == CONSEC_C);

    always_comb begin
        count_d = count_q;
        last_d  = last_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = adv_count;
        end
        if (tick) begin
            last_d = bit_in;
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            last_q  <= CAN_RECESSIVE;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign count    = count_q;
    assign last_bit = last_q;

endmodule

// File: rtl/can_stuff.sv
// Transmit-side CAN bit stuffer: inserts a complementary bit after CONSEC identical bits.
// Optional bus readback monitor (rxin/bit_err) is enabled by defining CAN_STUFF_BITMON_EN.
module can_stuff
    import can_pkg::*;
#(
    parameter int CONSEC = CAN_CONSEC_DEFAULT,
    parameter int CNT_W  = 4
) (
    input  logic clkin,
    input  logic rstn,
    input  logic bit_tick,
    input  logic en,
    input  logic din_valid,
    input  logic din,
`ifdef CAN_STUFF_BITMON_EN
    input  logic rxin,
    output logic bit_err,
`endif
    output logic din_ready,
    output logic txout,
    output logic stuffing,
    output logic err
);

    localparam logic [CNT_W-1:0] CONSEC_C = CNT_W'(CONSEC);

    can_stuff_state_t state_q, state_d;
    logic             txout_q, txout_d;
    logic             stuffing_q, stuffing_d;
    logic             err_q, err_d;
    logic             cnt_tick, cnt_clear, cnt_bit;
    logic [CNT_W-1:0] run_count;
    logic             last_bit, run_hit;

    // The stuff bit is fed back into the run tracker so it opens the next run.
    assign cnt_bit   = (state_q == STUFF) ? ~last_bit : din;
    assign din_ready = bit_tick && (state_q != STUFF) && din_valid;

    can_run_counter #(
        .CONSEC (CONSEC),
        .CNT_W  (CNT_W)
    ) u_run (
        .clkin    (clkin),
        .rstn     (rstn),
        .tick     (cnt_tick),
        .clear    (cnt_clear),
        .bit_in   (cnt_bit),
        .count    (run_count),
        .last_bit (last_bit),
        .run_hit  (run_hit)
    );

    // en is sampled at every tick, so a tick in IDLE with en=1 already stuffs its bit.
    always_comb begin
        state_d    = state_q;
        txout_d    = txout_q;
        stuffing_d = stuffing_q;
        err_d      = err_q;
        cnt_tick   = 1'b0;
        cnt_clear  = 1'b0;
        if (bit_tick) begin
            stuffing_d = 1'b0;
            if (state_q == STUFF) begin
                txout_d    = ~last_bit;
                cnt_tick   = 1'b1;
                stuffing_d = 1'b1;
                state_d    = en ? DATA : IDLE;
            end else if (en) begin
                state_d = DATA;
                if (din_valid) begin
                    txout_d  = din;
                    cnt_tick = 1'b1;
                    if (run_hit) begin
                        state_d = STUFF;
                    end
                end else begin
                    txout_d   = CAN_RECESSIVE;
                    err_d     = 1'b1;
                    cnt_clear = 1'b1;
                end
            end else begin
                state_d = IDLE;
                if (din_valid) begin
                    txout_d   = din;
                    cnt_tick  = 1'b1;
                    cnt_clear = 1'b1;
                end else begin
                    txout_d = CAN_RECESSIVE;
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            txout_q    <= CAN_RECESSIVE;
            stuffing_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            txout_q    <= txout_d;
            stuffing_q <= stuffing_d;
            err_q      <= err_d;
        end
    end

    assign txout    = txout_q;
    assign stuffing = stuffing_q;
    assign err      = err_q;

    assert property (@(posedge clkin) disable iff (!rstn) run_count <= CONSEC_C);

`ifdef CAN_STUFF_BITMON_EN
    logic bit_err_q, bit_err_d;

    // Only a dominant drive read back as recessive is an error; the reverse is lost arbitration.
    always_comb begin
        bit_err_d = bit_err_q;
        if (bit_tick && txout_q == CAN_DOMINANT && rxin == CAN_RECESSIVE) begin
            bit_err_d = 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            bit_err_q <= 1'b0;
        end else begin
            bit_err_q <= bit_err_d;
        end
    end

    assign bit_err = bit_err_q;
`endif

endmodule
